regpipe_elastic: RTL and testbench

//  - Parametrised DEPTH-stage register pipeline with valid/ready handshake at both ends.
//  - Bubbles collapse; full throughput of one word per cycle when both sides are ready.
//  - Adds global clock-enable stall, synchronous flush and an occupancy count.
//  - Sits between Rijndael round datapath stages (state/key words) where a plain

---
 rtl/regpipe_elastic_pkg.sv | 20 ++
 rtl/regpipe_elastic_stage.sv | 50 +++++
 rtl/regpipe_elastic.sv | 102 ++++++++++
 tb/tb_regpipe_elastic.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regpipe_elastic_pkg.sv
// Shared definitions for the elastic register pipeline: AES word width and a
// constant-friendly ceiling log2 used to size the occupancy counter.
package regpipe_elastic_pkg;

  localparam int AES_WORD_W = 128;

  // Bits needed to encode values 0..value-1; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regpipe_elastic_stage.sv
// One pipeline slot: a valid bit and a data word. Valid follows its source
// whenever the slot is free; data only captures real words.
module regpipe_stage
  import regpipe_elastic_pkg::*;
#(
  parameter int WIDTH = AES_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             en_i,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      // Flush drops occupancy only; stale data is harmless behind a cleared valid.
      valid_d = 1'b0;
    end else if (en_i) begin
      valid_d = src_valid_i;
      if (src_valid_i) begin
        data_d = src_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/regpipe_elastic.sv
// DEPTH-stage elastic pipeline with valid/ready at both ends, global clock
// enable, synchronous flush and an occupancy count.
module regpipe_elastic
  import regpipe_elastic_pkg::*;
#(
  parameter int WIDTH = AES_WORD_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clken,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_free;
  logic             active;
  logic             mv_out;
  logic             in_xfer;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Handshakes are suppressed while frozen or flushing so no word is lost or duplicated.
  assign active = clken & ~flush;
  assign mv_out = active & stage_valid[DEPTH-1] & out_ready;

  // Free chain walks from the output back to the input in one comb pass.
  always_comb begin
    logic downstream_free;
    stage_free      = '0;
    downstream_free = mv_out;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      stage_free[i]   = ~stage_valid[i] | downstream_free;
      downstream_free = stage_free[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;

      if (gi == 0) begin : g_head
        assign src_valid = in_valid;
        assign src_data  = in_data;
      end else begin : g_body
        assign src_valid = stage_valid[gi-1];
        assign src_data  = stage_data[gi-1];
      end

      regpipe_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .en_i       (clken & stage_free[gi]),
        .src_valid_i(src_valid),
        .src_data_i (src_data),
        .valid_o    (stage_valid[gi]),
        .data_o     (stage_data[gi])
      );
    end
  endgenerate

  assign in_ready  = active & stage_free[0] & rst_n;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = active & stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_xfer && !mv_out) begin
      count_d = count_q + CNT_W'(1);
    end else if (!in_xfer && mv_out) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_regpipe_elastic.sv
// Directed bench for regpipe_elastic (WIDTH=128, DEPTH=4): reset, latency,
// backpressure, simultaneous transfer, clock-enable stall and flush.
module tb_regpipe_elastic;

  localparam int W = 128;
  localparam int D = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          clken;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;

  int checks;
  int errors;

  regpipe_elastic #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clken    (clken),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = W'(base + k);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    clken = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_release got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_latency();
    int first;
    int n;
    logic [W-1:0] got [3];
    first = -1;
    n = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 3);
      in_data  = W'(k + 1);
      #1;
      if (k == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready got %b want 1", in_ready); end
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = k;
        if (n < 3) got[n] = out_data;
        n++;
        $display("latency emit cycle %0d data %h", k, out_data);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (first !== 4) begin errors++; $display("FAIL lat_first_valid got %0d want 4", first); end
    checks++; if (n !== 3) begin errors++; $display("FAIL lat_word_count got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== W'(i + 1)) begin errors++; $display("FAIL lat_order[%0d] got %h want %h", i, got[i], W'(i + 1)); end
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL lat_count_end got %0d want 0", count); end
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = W'(16 + k);
      #1;
      if (k == 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
      end
      if (in_ready === 1'b1) acc++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", acc); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count_full got %0d want 4", count); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== W'(16 + k)) begin
        errors++; $display("FAIL bp_drain[%0d] got v=%b %h want v=1 %h", k, out_valid, out_data, W'(16 + k));
      end
      $display("backpressure emit %h", out_data);
      tick();
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_valid got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bp_count_end got %0d want 0", count); end
    tick();
  endtask

  task automatic test_simultaneous();
    int nin;
    int nout;
    logic [W-1:0] exp_word;
    nin = 0;
    nout = 0;
    out_ready = 1'b0;
    push_words(4, 32);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL sim_fill_count got %0d want 4", count); end
    for (int k = 0; k < 14; k++) begin
      in_valid  = (k < 10);
      in_data   = W'(48 + k);
      out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) nin++;
      if (out_valid && out_ready) begin
        exp_word = (nout < 4) ? W'(32 + nout) : W'(48 + nout - 4);
        checks++; if (out_data !== exp_word) begin errors++; $display("FAIL sim_data[%0d] got %h want %h", nout, out_data, exp_word); end
        $display("simultaneous emit %h", out_data);
        nout++;
      end
      tick();
      if (k < 10) begin
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL sim_count[%0d] got %0d want 4", k, count); end
      end
    end
    in_valid = 1'b0;
    checks++; if (nin !== 10) begin errors++; $display("FAIL sim_in_total got %0d want 10", nin); end
    checks++; if (nout !== 14) begin errors++; $display("FAIL sim_out_total got %0d want 14", nout); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL sim_count_end got %0d want 0", count); end
  endtask

  task automatic test_stall();
    logic [W-1:0] q [$];
    logic [W-1:0] exp_word;
    logic [W-1:0] frozen_data;
    logic [CW-1:0] frozen_count;
    int sent;
    sent = 0;
    frozen_data = '0;
    frozen_count = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      clken    = !(k >= 5 && k < 8);
      in_valid = (k < 12);
      in_data  = W'(64 + sent);
      #1;
      if (k == 5) begin
        frozen_count = count;
        frozen_data  = out_data;
      end
      if (!clken) begin
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          errors++; $display("FAIL stall_handshake[%0d] got rdy=%b vld=%b want 0 0", k, in_ready, out_valid);
        end
        checks++; if (count !== frozen_count || out_data !== frozen_data) begin
          errors++; $display("FAIL stall_frozen[%0d] got %0d %h want %0d %h", k, count, out_data, frozen_count, frozen_data);
        end
      end
      if (k == 8) begin
        checks++; if (count !== frozen_count) begin errors++; $display("FAIL stall_resume_count got %0d want %0d", count, frozen_count); end
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL stall_dup got %h want none", out_data);
        end else begin
          exp_word = q.pop_front();
          checks++; if (out_data !== exp_word) begin errors++; $display("FAIL stall_data got %h want %h", out_data, exp_word); end
          $display("stall emit %h", out_data);
        end
      end
      tick();
    end
    clken = 1'b1;
    in_valid = 1'b0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL stall_lost got %0d want 0", q.size()); end
    checks++; if (sent < 9) begin errors++; $display("FAIL stall_sent got %0d want >=9", sent); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stall_count_end got %0d want 0", count); end
  endtask

  task automatic test_flush();
    int first;
    logic [W-1:0] got;
    first = -1;
    got = '0;
    out_ready = 1'b0;
    push_words(3, 80);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", count); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = W'(153);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_post_valid got %b want 0", out_valid); end
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k == 0);
      in_data  = W'(96);
      #1;
      if (out_valid === 1'b1 && first < 0) begin
        first = k;
        got   = out_data;
        $display("flush emit %h", out_data);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (first !== 4) begin errors++; $display("FAIL flush_refill_latency got %0d want 4", first); end
    checks++; if (got !== W'(96)) begin errors++; $display("FAIL flush_refill_data got %h want %h", got, W'(96)); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push_words(3, 112);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count got %0d want 3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_out_data got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready_held got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready_release got %b want 1", in_ready); end
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    clken     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_simultaneous();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
